// File: rtl/board_mem_arbiter_pkg.sv
// Shared board-memory definitions: geometry, cell encodings, channel map and arbiter FSM states.
package board_mem_arbiter_pkg;

    localparam int BOARD_ADDR_W = 7;
    localparam int BOARD_DATA_W = 2;

    localparam logic [BOARD_DATA_W-1:0] CELL_EMPTY = 2'b00;
    localparam logic [BOARD_DATA_W-1:0] CELL_BLACK = 2'b01;
    localparam logic [BOARD_DATA_W-1:0] CELL_WHITE = 2'b10;

    localparam int CH_INIT = 0;
    localparam int CH_VALI = 1;
    localparam int CH_FLIP = 2;
    localparam int CH_VGA  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/board_mem_arbiter_arb_pick.sv
// Combinational winner picker: fixed priority (highest index) or round-robin from a start pointer.
module arb_pick #(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 0,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] exclude,
    input  logic [PTR_W-1:0]  start,
    output logic [NUM_CH-1:0] winner
);

    logic [NUM_CH-1:0] cand;
    logic              found;
    int                idx;

    // Pick one candidate; excluded channels never win.
    always_comb begin
        cand   = req & ~exclude;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (RR_MODE != 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = (int'(start) + i) % NUM_CH;
                if (!found && cand[idx]) begin
                    winner[idx] = 1'b1;
                    found       = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cand[i]) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Board memory arbiter: grants one channel at a time, muxes its access onto the memory
// port and routes synchronous read data back to the channel that issued the read.
module board_mem_arbiter
    import board_mem_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = BOARD_ADDR_W,
    parameter int DATA_W   = BOARD_DATA_W,
    parameter int RR_MODE  = 0,
    parameter int HOLD_MAX = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*ADDR_W-1:0] addr_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        wren_in,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     wren_out,
    output logic [DATA_W-1:0]        rdata,
    output logic [NUM_CH-1:0]        rvalid
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_TOP  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [PTR_W-1:0] LAST_CH   = PTR_W'(NUM_CH - 1);

    arb_state_t        state, state_nxt;
    logic [PTR_W-1:0]  owner, last_owner, start_ptr, win_idx;
    logic [CNT_W-1:0]  hold_cnt;
    logic [NUM_CH-1:0] exclude, win;
    logic              own_req, own_wren, hold_hit, grant_new, mem_active;
    logic [DATA_W-1:0] rdata_hold;

    assign own_req   = req[owner];
    assign own_wren  = wren_in[owner];
    assign exclude   = (state == ST_BUSY) ? gnt : '0;
    assign start_ptr = (last_owner == LAST_CH) ? '0 : last_owner + 1'b1;
    assign hold_hit  = (HOLD_MAX > 0) && (hold_cnt >= HOLD_LAST);

    arb_pick #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req     (req),
        .exclude (exclude),
        .start   (start_ptr),
        .winner  (win)
    );

    // Convert the one-hot winner into a channel index.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

    // Next state: new grant from idle, handover on release, preemption once the hold budget is spent.
    always_comb begin
        state_nxt = state;
        grant_new = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|win) begin
                    state_nxt = ST_BUSY;
                    grant_new = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!own_req) begin
                    if (|win) grant_new = 1'b1;
                    else      state_nxt = ST_IDLE;
                end else if (hold_hit && |win) begin
                    grant_new = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, grant, owner bookkeeping and the saturating hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= LAST_CH;
            hold_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_new) begin
                gnt        <= win;
                owner      <= win_idx;
                last_owner <= win_idx;
                hold_cnt   <= '0;
            end else if (state_nxt == ST_IDLE) begin
                gnt      <= '0;
                hold_cnt <= '0;
            end else if ((HOLD_MAX > 0) && (hold_cnt != HOLD_TOP)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Tag a read with the issuing channel so the return follows it across a handover.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid     <= '0;
            rdata_hold <= '0;
        end else begin
            rvalid <= (state == ST_BUSY && own_req && !own_wren) ? gnt : '0;
            if (|rvalid) rdata_hold <= mem_rdata;
        end
    end

    assign rdata = (|rvalid) ? mem_rdata : rdata_hold;

    // Only an actively requesting owner drives the memory port; reset forces it quiet.
    assign mem_active = (state == ST_BUSY) && own_req && !rst;
    assign addr_out   = mem_active ? addr_in[int'(owner)*ADDR_W +: ADDR_W] : '0;
    assign data_out   = mem_active ? data_in[int'(owner)*DATA_W +: DATA_W] : '0;
    assign wren_out   = mem_active && own_wren;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: three configurations share one stimulus stream; an
// ownership-level model predicts every output each cycle, literal checks pin key cases.
module tb_board_mem_arbiter;
    import board_mem_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int AW   = 7;
    localparam int DW   = 2;
    localparam int NDUT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    wren_in = '0;
    logic [N*AW-1:0] addr_in;
    logic [N*DW-1:0] data_in;
    logic [DW-1:0]   mem_rdata = '0;

    logic [N-1:0]  gnt_o    [NDUT];
    logic [AW-1:0] addr_o   [NDUT];
    logic [DW-1:0] data_o   [NDUT];
    logic          wren_o   [NDUT];
    logic [DW-1:0] rdata_o  [NDUT];
    logic [N-1:0]  rvalid_o [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    board_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .HOLD_MAX(0)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .data_in(data_in), .wren_in(wren_in),
        .mem_rdata(mem_rdata), .gnt(gnt_o[0]), .addr_out(addr_o[0]), .data_out(data_o[0]),
        .wren_out(wren_o[0]), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]));

    board_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .HOLD_MAX(0)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .data_in(data_in), .wren_in(wren_in),
        .mem_rdata(mem_rdata), .gnt(gnt_o[1]), .addr_out(addr_o[1]), .data_out(data_o[1]),
        .wren_out(wren_o[1]), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]));

    board_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .HOLD_MAX(3)) dut_hm (
        .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .data_in(data_in), .wren_in(wren_in),
        .mem_rdata(mem_rdata), .gnt(gnt_o[2]), .addr_out(addr_o[2]), .data_out(data_o[2]),
        .wren_out(wren_o[2]), .rdata(rdata_o[2]), .rvalid(rvalid_o[2]));

    // Model configuration and state per instance: owner -1 means nobody owns the memory.
    int            m_rr    [NDUT] = '{0, 1, 0};
    int            m_holdm [NDUT] = '{0, 0, 3};
    int            m_owner [NDUT];
    int            m_last  [NDUT];
    int            m_cnt   [NDUT];
    int            m_rv    [NDUT];
    logic [DW-1:0] m_rdh   [NDUT];
    bit            armed = 1'b0;

    task automatic check(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, a, e);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int excl, input int rr, input int last);
        int w;
        w = -1;
        if (rr != 0) begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && ((last + k) % N) != excl && r[(last + k) % N]) w = (last + k) % N;
            end
        end else begin
            for (int c = N - 1; c >= 0; c--) begin
                if (w < 0 && c != excl && r[c]) w = c;
            end
        end
        return w;
    endfunction

    // Ownership model advanced at each edge from the inputs sampled there.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            int o;
            int w;
            if (rst) begin
                m_owner[d] = -1; m_last[d] = N - 1; m_cnt[d] = 0; m_rv[d] = -1; m_rdh[d] = '0;
                armed = 1'b1;
            end else begin
                o = m_owner[d];
                if (m_rv[d] >= 0) m_rdh[d] = mem_rdata;
                m_rv[d] = (o >= 0 && req[o] && !wren_in[o]) ? o : -1;
                if (o < 0) begin
                    w = pick(req, -1, m_rr[d], m_last[d]);
                end else if (!req[o]) begin
                    w = pick(req, o, m_rr[d], m_last[d]);
                    if (w < 0) m_owner[d] = -1;
                end else if (m_holdm[d] > 0 && m_cnt[d] + 1 >= m_holdm[d]) begin
                    w = pick(req, o, m_rr[d], m_last[d]);
                    if (w < 0) m_cnt[d]++;
                end else begin
                    w = -1;
                    m_cnt[d]++;
                end
                if (w >= 0) begin
                    m_owner[d] = w; m_last[d] = w; m_cnt[d] = 0;
                end
            end
        end
    end

    logic [N-1:0]  c_eg, c_erv;
    logic          c_act;
    int            c_ix;

    // Compare every output of every instance against the model mid-cycle.
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < NDUT; d++) begin
                c_eg  = '0;
                c_erv = '0;
                c_ix  = (m_owner[d] < 0) ? 0 : m_owner[d];
                if (m_owner[d] >= 0) c_eg[m_owner[d]] = 1'b1;
                if (m_rv[d] >= 0) c_erv[m_rv[d]] = 1'b1;
                c_act = (m_owner[d] >= 0) && req[c_ix] && !rst;
                check("gnt",    d, 32'(gnt_o[d]),    32'(c_eg));
                check("addr",   d, 32'(addr_o[d]),   c_act ? 32'(addr_in[c_ix*AW +: AW]) : 32'd0);
                check("data",   d, 32'(data_o[d]),   c_act ? 32'(data_in[c_ix*DW +: DW]) : 32'd0);
                check("wren",   d, 32'(wren_o[d]),   32'(c_act && wren_in[c_ix]));
                check("rvalid", d, 32'(rvalid_o[d]), 32'(c_erv));
                check("rdata",  d, 32'(rdata_o[d]),  (m_rv[d] >= 0) ? 32'(mem_rdata) : 32'(m_rdh[d]));
            end
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] w, input logic [DW-1:0] md, input logic rs);
        @(posedge clk);
        #1;
        req = r; wren_in = w; mem_rdata = md; rst = rs;
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        cyc(4'b0000, 4'b0000, 2'b00, 1'b1);
    endtask

    initial begin
        addr_in = '0;
        data_in = '0;
        addr_in[CH_INIT*AW +: AW] = 7'd27;
        addr_in[CH_VALI*AW +: AW] = 7'd101;
        addr_in[CH_FLIP*AW +: AW] = 7'd12;
        addr_in[CH_VGA*AW  +: AW] = 7'd63;
        data_in[CH_INIT*DW +: DW] = 2'b11;
        data_in[CH_VALI*DW +: DW] = CELL_WHITE;
        data_in[CH_FLIP*DW +: DW] = CELL_WHITE;
        data_in[CH_VGA*DW  +: DW] = CELL_BLACK;

        // Reset state
        rst_pulse();
        cyc(4'b0000, 4'b0000, 2'b00, 1'b0);
        check("lit_rst_gnt",   0, 32'(gnt_o[0]),    32'd0);
        check("lit_rst_rv",    1, 32'(rvalid_o[1]), 32'd0);
        check("lit_rst_rdata", 2, 32'(rdata_o[2]),  32'(CELL_EMPTY));

        // Fixed priority: 0101 -> channel 2, then handover to channel 0
        rst_pulse();
        cyc(4'b0101, 4'b0000, 2'b00, 1'b0);
        cyc(4'b0101, 4'b0000, 2'b00, 1'b0);
        check("lit_fp_gnt2",  0, 32'(gnt_o[0]),  32'h4);
        check("lit_fp_addr2", 0, 32'(addr_o[0]), 32'd12);
        cyc(4'b0001, 4'b0000, 2'b00, 1'b0);
        cyc(4'b0000, 4'b0000, 2'b00, 1'b0);
        check("lit_fp_gnt0",  0, 32'(gnt_o[0]),  32'h1);
        cyc(4'b0000, 4'b0000, 2'b00, 1'b0);

        // Round robin: every owner releases after one cycle, grants 0,1,2,3,0
        rst_pulse();
        cyc(4'b1111, 4'b0000, 2'b00, 1'b0);
        cyc(4'b1110, 4'b0000, 2'b00, 1'b0);
        check("lit_rr_g0", 1, 32'(gnt_o[1]), 32'h1);
        cyc(4'b1101, 4'b0000, 2'b00, 1'b0);
        check("lit_rr_g1", 1, 32'(gnt_o[1]), 32'h2);
        cyc(4'b1011, 4'b0000, 2'b00, 1'b0);
        check("lit_rr_g2", 1, 32'(gnt_o[1]), 32'h4);
        cyc(4'b0111, 4'b0000, 2'b00, 1'b0);
        check("lit_rr_g3", 1, 32'(gnt_o[1]), 32'h8);
        cyc(4'b0000, 4'b0000, 2'b00, 1'b0);
        check("lit_rr_g0b", 1, 32'(gnt_o[1]), 32'h1);

        // Hold limit 3: channel 1 holds against channel 3
        rst_pulse();
        cyc(4'b0010, 4'b0000, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1010, 4'b0000, 2'b00, 1'b0);
            check("lit_hm_own1", 2, 32'(gnt_o[2]), 32'h2);
        end
        cyc(4'b1010, 4'b0000, 2'b00, 1'b0);
        check("lit_hm_pre3", 2, 32'(gnt_o[2]), 32'h8);
        rst_pulse();
        cyc(4'b0010, 4'b0000, 2'b00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0010, 4'b0010, 2'b00, 1'b0);
            check("lit_hm_alone", 2, 32'(gnt_o[2]), 32'h2);
        end

        // Read return for owner 0 at address 27
        rst_pulse();
        cyc(4'b0001, 4'b0000, 2'b00, 1'b0);
        cyc(4'b0001, 4'b0000, 2'b00, 1'b0);
        check("lit_rd_addr", 0, 32'(addr_o[0]), 32'd27);
        cyc(4'b0000, 4'b0000, 2'b10, 1'b0);
        check("lit_rd_rv",    0, 32'(rvalid_o[0]), 32'h1);
        check("lit_rd_rdata", 0, 32'(rdata_o[0]),  32'h2);

        // Read return while the reader is preempted on the same edge
        rst_pulse();
        cyc(4'b0001, 4'b0000, 2'b01, 1'b0);
        cyc(4'b0001, 4'b0000, 2'b01, 1'b0);
        cyc(4'b0001, 4'b0000, 2'b01, 1'b0);
        cyc(4'b0011, 4'b0000, 2'b01, 1'b0);
        check("lit_ho_addr", 2, 32'(addr_o[2]), 32'd27);
        cyc(4'b0010, 4'b0010, 2'b10, 1'b0);
        check("lit_ho_gnt",   2, 32'(gnt_o[2]),    32'h2);
        check("lit_ho_rv",    2, 32'(rvalid_o[2]), 32'h1);
        check("lit_ho_rdata", 2, 32'(rdata_o[2]),  32'h2);
        cyc(4'b0010, 4'b0010, 2'b11, 1'b0);
        check("lit_hold_rv",    2, 32'(rvalid_o[2]), 32'h0);
        check("lit_hold_rdata", 2, 32'(rdata_o[2]),  32'h2);

        // Write by owner 3, then reset while busy
        rst_pulse();
        cyc(4'b1000, 4'b1000, 2'b00, 1'b0);
        cyc(4'b1000, 4'b1000, 2'b00, 1'b0);
        check("lit_wr_gnt",  1, 32'(gnt_o[1]),  32'h8);
        check("lit_wr_wren", 1, 32'(wren_o[1]), 32'h1);
        check("lit_wr_addr", 1, 32'(addr_o[1]), 32'd63);
        check("lit_wr_data", 1, 32'(data_o[1]), 32'h1);
        cyc(4'b1010, 4'b1000, 2'b00, 1'b1);
        check("lit_wr_rstwren", 1, 32'(wren_o[1]), 32'h0);
        cyc(4'b0110, 4'b0000, 2'b00, 1'b0);
        check("lit_post_gnt",  1, 32'(gnt_o[1]),    32'h0);
        check("lit_post_rv",   1, 32'(rvalid_o[1]), 32'h0);
        check("lit_post_wren", 1, 32'(wren_o[1]),   32'h0);
        cyc(4'b0110, 4'b0000, 2'b00, 1'b0);
        check("lit_post_rr", 1, 32'(gnt_o[1]), 32'h2);

        // Mixed traffic with a reset in the middle
        for (int i = 0; i < 48; i++) begin
            cyc(4'((i * 5 + 3) ^ (i >> 2)), 4'((i * 3) >> 1), 2'(i), (i == 30));
        end

        cyc(4'b0000, 4'b0000, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
